spi_cmd_master: RTL and testbench

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

---
 rtl/spi_cmd_master.sv | 178 +++++++++++++++++
 tb/tb_spi_cmd_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 frame master. It sends one FRAME_BITS frame MSB first
// under an active-low SSEL, and each SCK half-period lasts CLK_DIV cycles.
// Optional build macro SPI_CMD_MASTER_RX_EN: when defined, MISO is captured into rx_data.
// Without it, rx_data is tied to 0. Frame timing is the same in both builds.
module spi_cmd_master #(
    parameter int unsigned FRAME_BITS = 88,
    parameter int unsigned CLK_DIV    = 25
) (
    input  logic                  clk50M,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  SCK,
    output logic                  MOSI,
    output logic                  SSEL,
    input  logic                  MISO
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic                  ssel_q, ssel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  half_end;
    logic                  last_bit;
    logic                  rise_c;
    logic                  finish_c;

    assign half_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign last_bit = (bit_cnt_q == BIT_W'(FRAME_BITS));

    // State and output registers; every SPI pin comes straight from a flop
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ssel_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ssel_q    <= ssel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: half-period sequencing, SCK edges and MOSI shifting
    always_comb begin
        state_d   = state_q;
        cnt_d     = half_end ? '0 : cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ssel_d    = ssel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rise_c    = 1'b0;
        finish_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    tx_sr_d   = tx_data;
                    mosi_d    = tx_data[FRAME_BITS-1];
                    ssel_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (half_end) begin
                    sck_d     = 1'b1;
                    bit_cnt_d = BIT_W'(1);
                    rise_c    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    if (sck_q) begin
                        // Falling edge: present the next bit unless the frame is complete
                        sck_d = 1'b0;
                        if (!last_bit) begin
                            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                            mosi_d  = tx_sr_q[FRAME_BITS-2];
                        end
                    end else if (last_bit) begin
                        state_d = HOLD;
                    end else begin
                        sck_d     = 1'b1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        rise_c    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    ssel_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (half_end) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    finish_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign SCK  = sck_q;
    assign MOSI = mosi_q;
    assign SSEL = ssel_q;

`ifdef SPI_CMD_MASTER_RX_EN
    logic [FRAME_BITS-1:0] rx_sr_q;
    logic [FRAME_BITS-1:0] rx_data_q;

    // MISO capture on each SCK rise; rx_data is published only when a frame completes
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr_q   <= '0;
            rx_data_q <= '0;
        end else begin
            if (rise_c) begin
                rx_sr_q <= {rx_sr_q[FRAME_BITS-2:0], MISO};
            end
            if (finish_c) begin
                rx_data_q <= rx_sr_q;
            end
        end
    end

    assign rx_data = rx_data_q;
`else
    logic rx_unused;

    assign rx_unused = ^{MISO, rise_c, finish_c};
    assign rx_data   = '0;
`endif

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: random and directed frames on a small instance (8 bits, CLK_DIV 2).
// The small instance is checked each cycle against a frame-offset model.
// A default-parameter instance is checked for its timing and bit order.
module tb_spi_cmd_master;
    localparam int N     = 8;
    localparam int D     = 2;
    localparam int FL    = (2 * N + 3) * D;
    localparam int IDX_W = $clog2(N);
    localparam int ND    = 88;
    localparam int DD    = 25;
    localparam int DFL   = (2 * ND + 3) * DD;

    logic clk50M = 1'b0;
    always #10 clk50M = ~clk50M;

    // small instance
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] tx_data = '0;
    logic         busy, done, sck, mosi, ssel, miso;
    logic [N-1:0] rx_data;
    logic [N-1:0] miso_pat = '0;

    spi_cmd_master #(.FRAME_BITS(N), .CLK_DIV(D)) dut (
        .clk50M(clk50M), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .SCK(sck), .MOSI(mosi), .SSEL(ssel), .MISO(miso)
    );

    // default instance
    logic          d_rst_n = 1'b1;
    logic          d_start = 1'b0;
    logic [ND-1:0] d_tx = '0;
    logic          d_busy, d_done, d_sck, d_mosi, d_ssel;
    logic          d_miso = 1'b0;
    logic [ND-1:0] d_rx;

    spi_cmd_master dut_def (
        .clk50M(clk50M), .rst_n(d_rst_n), .start(d_start), .tx_data(d_tx),
        .busy(d_busy), .done(d_done), .rx_data(d_rx),
        .SCK(d_sck), .MOSI(d_mosi), .SSEL(d_ssel), .MISO(d_miso)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    endtask

    // mode-0 slave: the first bit is valid at SSEL fall, and the next bit follows each SCK fall
    int sl_falls = 0;
    always @(negedge sck) if (!ssel) sl_falls++;
    always @(negedge ssel) sl_falls = 0;
    assign miso = (!ssel && sl_falls < N) ? miso_pat[IDX_W'(N - 1 - sl_falls)] : 1'b0;

    // frame model: the expected pins follow from the cycle offset since acceptance
    bit           m_act = 0;
    bit           m_done = 0;
    int           m_o = 0;
    logic [N-1:0] m_tx = '0, m_pat = '0, m_rx = '0;
    logic         m_mosi_idle = 1'b0;

    always @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_o = 0; m_rx = '0; m_mosi_idle = 1'b0;
        end else begin
            m_done = 0;
            if (m_act) begin
                m_o++;
                if (m_o == FL) begin
                    m_act = 0;
                    m_done = 1;
                    m_mosi_idle = m_tx[0];
`ifdef SPI_CMD_MASTER_RX_EN
                    m_rx = m_pat;
`else
                    m_rx = '0;
`endif
                end
            end else if (start) begin
                m_act = 1; m_o = 0; m_tx = tx_data; m_pat = miso_pat;
            end
        end
    end

    logic e_busy, e_ssel, e_sck, e_mosi, e_done;
    int   e_falls;

    // every-cycle comparison of the small instance against the model
    always @(negedge clk50M) begin
        if (m_act) begin
            e_busy  = 1'b1;
            e_done  = 1'b0;
            e_ssel  = (m_o < (2 * N + 2) * D) ? 1'b0 : 1'b1;
            e_sck   = (m_o >= D) && (m_o < (2 * N + 1) * D) && (((m_o / D) % 2) == 1);
            e_falls = m_o / (2 * D);
            if (e_falls > N - 1) e_falls = N - 1;
            e_mosi  = m_tx[IDX_W'(N - 1 - e_falls)];
        end else begin
            e_busy = 1'b0;
            e_done = m_done;
            e_ssel = 1'b1;
            e_sck  = 1'b0;
            e_mosi = m_mosi_idle;
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("ssel", ssel, e_ssel);
        check("sck", sck, e_sck);
        check("mosi", mosi, e_mosi);
        check("rx_data", rx_data, m_rx);
    end

    // MOSI seen by the slave on each SCK rise, restarted at each SSEL fall
    logic         prev_sck = 1'b0, prev_ssel = 1'b1;
    int           rises = 0;
    logic [N-1:0] mosi_cap = '0;
    always @(negedge clk50M) begin
        if (prev_ssel && !ssel) begin
            rises = 0;
            mosi_cap = '0;
        end
        if (!prev_sck && sck) begin
            rises++;
            mosi_cap = {mosi_cap[N-2:0], mosi};
        end
        prev_sck  = sck;
        prev_ssel = ssel;
    end

    // Launches one frame from a negedge; optional stray start pulse and tx change mid-frame
    task automatic run_frame(input logic [N-1:0] tx, input logic [N-1:0] pat,
                             input int inj, input int chg, output int cyc);
        logic [N-1:0] r;
        tx_data = tx; miso_pat = pat; start = 1'b1; cyc = 0;
        while (cyc < FL + 10) begin
            @(negedge clk50M);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (inj != 0 && cyc == inj) start = 1'b1;
            if (inj != 0 && cyc == inj + 1) start = 1'b0;
            if (chg != 0 && cyc == chg) begin
                r = N'($urandom);
                tx_data = r;
            end
            if (done) break;
        end
        check("frame_len", cyc, FL + 1);
        check("frame_rises", rises, N);
        check("frame_mosi", mosi_cap, tx);
    endtask

    logic [N-1:0] exp_3c;
    logic [N-1:0] rt, rp;
    int           cyc, gap_cnt, k;
    bit           dflt_fin = 0;

    // default-parameter instance: bit order, SCK period and frame length
    initial begin : dflt
        int dcyc, drises, dlast, pmin, pmax;
        logic dprev;
        logic [ND-1:0] dbits;
        #1 d_rst_n = 1'b0;
        repeat (3) @(negedge clk50M);
        d_rst_n = 1'b1;
        d_tx = 88'h0123456789ABCDEF012345;
        d_start = 1'b1;
        dcyc = 0; drises = 0; dlast = 0; pmin = 1000000; pmax = 0;
        dprev = d_sck; dbits = '0;
        while (dcyc < DFL + 20) begin
            @(negedge clk50M);
            dcyc++;
            if (dcyc == 1) d_start = 1'b0;
            if (!dprev && d_sck) begin
                drises++;
                dbits = {dbits[ND-2:0], d_mosi};
                if (drises > 1) begin
                    if (dcyc - dlast < pmin) pmin = dcyc - dlast;
                    if (dcyc - dlast > pmax) pmax = dcyc - dlast;
                end
                dlast = dcyc;
            end
            dprev = d_sck;
            if (d_done) break;
        end
        check("dflt_len", dcyc, 4476);
        check("dflt_rises", drises, 88);
        check("dflt_period_min", pmin, 50);
        check("dflt_period_max", pmax, 50);
        check("dflt_bits", dbits, 88'h0123456789ABCDEF012345);
        check("dflt_busy_at_done", d_busy, 1'b0);
        check("dflt_ssel_at_done", d_ssel, 1'b1);
        check("dflt_rx", d_rx, '0);
        dflt_fin = 1;
    end

    initial begin : main
`ifdef SPI_CMD_MASTER_RX_EN
        exp_3c = 8'h3C;
`else
        exp_3c = 8'h00;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk50M);
        check("rst_busy", busy, 1'b0);
        check("rst_ssel", ssel, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx", rx_data, 8'h00);
        rst_n = 1'b1;

        // A5 out, 3C back; start accepted on the first edge after reset release
        run_frame(8'hA5, 8'h3C, 0, 0, cyc);
        check("a5_len", cyc, 39);
        check("a5_rises", rises, 8);
        check("a5_mosi", mosi_cap, 8'hA5);
        check("a5_rx", rx_data, exp_3c);

        // start held high: second frame accepted in the done cycle, tx change ignored
        @(negedge clk50M);
        tx_data = 8'h01; miso_pat = 8'h00; start = 1'b1;
        cyc = 0; gap_cnt = 0;
        while (cyc < FL + 10) begin
            @(negedge clk50M);
            cyc++;
            if (cyc == 5) tx_data = 8'hFF;
            if (ssel && busy) gap_cnt++;
            if (done) break;
        end
        check("b2b_len1", cyc, 39);
        check("b2b_gap", gap_cnt, 2);
        check("b2b_mosi1", mosi_cap, 8'h01);
        check("b2b_busy_done", busy, 1'b0);
        cyc = 0;
        while (cyc < FL + 10) begin
            @(negedge clk50M);
            cyc++;
            if (cyc == 1) begin
                check("b2b_accept_busy", busy, 1'b1);
                check("b2b_accept_ssel", ssel, 1'b0);
                start = 1'b0;
            end
            if (done) break;
        end
        check("b2b_len2", cyc, 39);
        check("b2b_mosi2", mosi_cap, 8'hFF);

        // rx_data holds between frames, then reset mid-frame clears it
        @(negedge clk50M);
        run_frame(8'h5A, 8'h3C, 0, 0, cyc);
        repeat (3) @(negedge clk50M);
        check("rx_hold", rx_data, exp_3c);
        tx_data = 8'hC3; miso_pat = 8'h96; start = 1'b1;
        @(negedge clk50M);
        start = 1'b0;
        k = 0;
        while (k < FL) begin
            @(negedge clk50M);
            #2;
            k++;
            if (rises >= 4) break;
        end
        check("rst_mid_reached_bit4", rises >= 4, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_ssel", ssel, 1'b1);
        check("rst_mid_sck", sck, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_mosi", mosi, 1'b0);
        check("rst_mid_rx", rx_data, 8'h00);
        @(negedge clk50M);
        rst_n = 1'b1;
        run_frame(8'h69, 8'hE1, 0, 0, cyc);

        // random frames with stray start pulses, tx changes and random idle gaps
        for (int f = 0; f < 16; f++) begin
            int inj, chg, gap;
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, FL - 5)) : 0;
            chg = int'($urandom_range(2, FL - 2));
            gap = int'($urandom_range(0, 3));
            rt = N'($urandom);
            rp = N'($urandom);
            run_frame(rt, rp, inj, chg, cyc);
            repeat (gap) @(negedge clk50M);
        end

        k = 0;
        while (!dflt_fin && k < 10000) begin
            @(negedge clk50M);
            k++;
        end
        check("dflt_finished", dflt_fin, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
